// File: rtl/output_port_scheduler_if.sv
// Handshake/bus bundle between the five router inputs and one output scheduler.
// The master side presents flits and credits; the slave side is the scheduler.
interface output_port_scheduler_if #(
    parameter int CW = 3
);
    logic [4:0]    req;
    logic [14:0]   flit_id;
    logic          credit_in;
    logic [4:0]    grant;
    logic [2:0]    xbar_sel;
    logic          flit_fire;
    logic [CW-1:0] credits;
    logic          busy;
    logic          timeout_err;

    modport master (
        output req, flit_id, credit_in,
        input  grant, xbar_sel, flit_fire, credits, busy, timeout_err
    );

    modport slave (
        input  req, flit_id, credit_in,
        output grant, xbar_sel, flit_fire, credits, busy, timeout_err
    );
endinterface

// File: rtl/output_port_scheduler.sv
// Output-port scheduler: round-robin wormhole arbiter with credit gating.
// Optional watchdog release enabled by defining SCHED_WATCHDOG_EN.
module output_port_scheduler #(
    parameter int CREDIT_DEPTH = 4,
    parameter int CW           = 3,
    parameter int TIMEOUT      = 256,
    parameter int TW           = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    output_port_scheduler_if.slave   bus
);
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;
    localparam logic [2:0] SEL_NONE = 3'b111;

    logic [0:0]    state_q, state_d;
    logic [4:0]    grant_q, grant_d;
    logic [2:0]    sel_q, sel_d;
    logic [2:0]    rr_q, rr_d;
    logic [CW-1:0] cred_q, cred_d;
    logic          terr_q, terr_d;

    logic [4:0]    elig;
    logic          found;
    logic [2:0]    win;
    logic          own_req;
    logic [2:0]    own_fid;
    logic          fire;
    logic          has_cred;

`ifdef SCHED_WATCHDOG_EN
    logic [TW-1:0] wd_q, wd_d;
`else
    logic          unused_cfg;
    assign unused_cfg = ^{TIMEOUT[0], TW[0]};
`endif

    // Heads that may open a new packet: header or single-flit.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            elig[i] = bus.req[i] &
                      ((bus.flit_id[3*i +: 3] == 3'b001) ||
                       (bus.flit_id[3*i +: 3] == 3'b111));
        end
    end

    // Round-robin pick: first eligible input starting at rr_q.
    always_comb begin
        logic [3:0] s;
        found = 1'b0;
        win   = 3'd0;
        s     = 4'd0;
        for (int k = 0; k < 5; k++) begin
            s = {1'b0, rr_q} + 4'(k);
            if (s >= 4'd5) s = s - 4'd5;
            if (!found && elig[s[2:0]]) begin
                found = 1'b1;
                win   = s[2:0];
            end
        end
    end

    // Select the owner's request and flit type.
    always_comb begin
        own_req = 1'b0;
        own_fid = 3'b000;
        case (sel_q)
            3'd0: begin own_req = bus.req[0]; own_fid = bus.flit_id[2:0];   end
            3'd1: begin own_req = bus.req[1]; own_fid = bus.flit_id[5:3];   end
            3'd2: begin own_req = bus.req[2]; own_fid = bus.flit_id[8:6];   end
            3'd3: begin own_req = bus.req[3]; own_fid = bus.flit_id[11:9];  end
            3'd4: begin own_req = bus.req[4]; own_fid = bus.flit_id[14:12]; end
            default: ;
        endcase
    end

    assign has_cred = (cred_q != '0);
    assign fire     = (state_q == S_LOCKED) & own_req & has_cred;

    // Arbitration, wormhole lock and release decisions.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        terr_d  = 1'b0;
`ifdef SCHED_WATCHDOG_EN
        wd_d    = wd_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (found && has_cred) begin
                    state_d = S_LOCKED;
                    grant_d = 5'b00001 << win;
                    sel_d   = win;
                    rr_d    = (win == 3'd4) ? 3'd0 : win + 3'd1;
`ifdef SCHED_WATCHDOG_EN
                    wd_d    = '0;
`endif
                end
            end
            default: begin
                if (fire) begin
`ifdef SCHED_WATCHDOG_EN
                    wd_d = '0;
`endif
                    if (own_fid == 3'b100 || own_fid == 3'b111) begin
                        state_d = S_IDLE;
                        grant_d = 5'b00000;
                        sel_d   = SEL_NONE;
                    end
                end
`ifdef SCHED_WATCHDOG_EN
                else if (wd_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    grant_d = 5'b00000;
                    sel_d   = SEL_NONE;
                    terr_d  = 1'b1;
                    wd_d    = '0;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
        endcase
    end

    // Credit mirror of the downstream buffer, saturating at full.
    always_comb begin
        cred_d = cred_q;
        if (fire && !bus.credit_in) begin
            cred_d = cred_q - 1'b1;
        end else if (!fire && bus.credit_in &&
                     cred_q != CW'(CREDIT_DEPTH)) begin
            cred_d = cred_q + 1'b1;
        end
    end

    // State registers; reset aborts any lock in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= 5'b00000;
            sel_q   <= SEL_NONE;
            rr_q    <= 3'd0;
            cred_q  <= CW'(CREDIT_DEPTH);
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            cred_q  <= cred_d;
            terr_q  <= terr_d;
        end
    end

`ifdef SCHED_WATCHDOG_EN
    // Watchdog counter for stalled locks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wd_q <= '0;
        else     wd_q <= wd_d;
    end
`endif

    assign bus.grant       = grant_q;
    assign bus.xbar_sel    = sel_q;
    assign bus.flit_fire   = fire;
    assign bus.credits     = cred_q;
    assign bus.busy        = (state_q == S_LOCKED);
    assign bus.timeout_err = terr_q;
endmodule
